// File: rtl/regfile_pkg.sv
// Shared defaults and the byte-merge helper for the scoreboarded register file.
// The helper works on a fixed maximum width; callers zero-extend and truncate.
package regfile_pkg;

   localparam int RF_DATA_W   = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_ZERO_REG = 1;
   localparam int RF_BYPASS   = 1;

   localparam int MAX_DATA_W  = 256;
   localparam int MAX_BE_W    = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] merged;
      merged = old_word;
      for (int b = 0; b < MAX_BE_W; b++) begin
         if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/regfile_sb_read_port.sv
// One combinational read port: decode, zero-register mask, write bypass and busy mask.
// Holds no state; everything it reads comes from the top level.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = RF_ZERO_REG,
   parameter int BYPASS   = RF_BYPASS
) (
   input  logic                                 i_in_reset,
   input  logic [ADDR_W-1:0]                    i_rd_addr,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   i_regs,
   input  logic [(2**ADDR_W)-1:0]               i_pending,
   input  logic                                 i_we,
   input  logic [ADDR_W-1:0]                    i_wr_addr,
   input  logic [DATA_W-1:0]                    i_wr_data,
   input  logic [DATA_W/8-1:0]                  i_wr_be,
   input  logic                                 i_issue_valid,
   input  logic [ADDR_W-1:0]                    i_issue_addr,
   output logic [DATA_W-1:0]                    o_rd_data,
   output logic                                 o_rd_busy
);

   localparam bit ZR  = (ZERO_REG != 0);
   localparam bit BYP = (BYPASS != 0);

   logic              w_is_zero;
   logic              w_wr_hit;
   logic              w_clearing;
   logic [DATA_W-1:0] w_stored;
   logic [DATA_W-1:0] w_merged;

   assign w_is_zero  = ZR && (i_rd_addr == '0);
   assign w_stored   = i_regs[i_rd_addr];
   assign w_merged   = DATA_W'(byte_merge(MAX_DATA_W'(w_stored), MAX_DATA_W'(i_wr_data),
                                          MAX_BE_W'(i_wr_be)));
   assign w_wr_hit   = BYP && i_we && (i_wr_addr == i_rd_addr) && !w_is_zero;
   // A same-edge issue to this register keeps it pending, so the write is not clearing it.
   assign w_clearing = w_wr_hit && !(i_issue_valid && (i_issue_addr == i_rd_addr));

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      o_rd_data = w_stored;
      o_rd_busy = i_pending[i_rd_addr];
      if (w_wr_hit)   o_rd_data = w_merged;
      if (w_clearing) o_rd_busy = 1'b0;
      if (w_is_zero)  o_rd_data = '0;
      if (i_in_reset) begin
         o_rd_data = '0;
         o_rd_busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with byte-enabled writes, optional write bypass and a per-register
// pending scoreboard with a running count of outstanding producers.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = RF_ZERO_REG,
   parameter int BYPASS   = RF_BYPASS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   rd_addr1,
   input  logic [ADDR_W-1:0]   rd_addr2,
   output logic [DATA_W-1:0]   rd_data1,
   output logic [DATA_W-1:0]   rd_data2,
   output logic                rd_busy1,
   output logic                rd_busy2,
   input  logic                we,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_addr,
   output logic [ADDR_W:0]     pend_cnt,
   input  logic [ADDR_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);

   localparam int NREG  = 2**ADDR_W;
   localparam int CNT_W = ADDR_W + 1;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [NREG-1:0][DATA_W-1:0] r_regs;
   logic [NREG-1:0]             r_pending;
   logic [CNT_W-1:0]            r_pend_cnt;

   logic                        w_in_reset;
   logic                        w_wr_ok;
   logic                        w_issue_ok;
   logic                        w_set_new;
   logic                        w_clr;
   logic [DATA_W-1:0]           w_wr_merged;

   assign w_in_reset  = !reset;
   assign w_wr_ok     = !(ZR && (wr_addr == '0));
   assign w_issue_ok  = !(ZR && (issue_addr == '0));
   assign w_wr_merged = DATA_W'(byte_merge(MAX_DATA_W'(r_regs[wr_addr]), MAX_DATA_W'(wr_data),
                                           MAX_BE_W'(wr_be)));

   // Counter deltas: a bit counts as cleared only if the same edge does not re-issue it.
   assign w_set_new = issue_valid && w_issue_ok && !r_pending[issue_addr];
   assign w_clr     = we && r_pending[wr_addr] &&
                      !(issue_valid && w_issue_ok && (issue_addr == wr_addr));

   // NOTE: the array is reset explicitly because reads must return 0 after reset; this
   // forces flops rather than a RAM macro, which is acceptable at this size.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_regs <= '0;
      end else if (we && w_wr_ok) begin
         r_regs[wr_addr] <= w_wr_merged;
      end
   end

   // NOTE: with non-blocking assignments the last one scheduled wins, so the issue
   // set placed after the write clear gives issue priority on a shared address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
      end else begin
         if (we)                        r_pending[wr_addr]    <= 1'b0;
         if (issue_valid && w_issue_ok) r_pending[issue_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_cnt <= '0;
      end else begin
         unique case ({w_set_new, w_clr})
            2'b10:   r_pend_cnt <= r_pend_cnt + CNT_W'(1);
            2'b01:   r_pend_cnt <= r_pend_cnt - CNT_W'(1);
            default: r_pend_cnt <= r_pend_cnt;
         endcase
      end
   end

   assign pend_cnt = r_pend_cnt;
   assign dbg_data = (w_in_reset || (ZR && (dbg_addr == '0))) ? '0 : r_regs[dbg_addr];

   rf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd_port1 (
      .i_in_reset   (w_in_reset),
      .i_rd_addr    (rd_addr1),
      .i_regs       (r_regs),
      .i_pending    (r_pending),
      .i_we         (we),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_wr_be      (wr_be),
      .i_issue_valid(issue_valid),
      .i_issue_addr (issue_addr),
      .o_rd_data    (rd_data1),
      .o_rd_busy    (rd_busy1)
   );

   rf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rd_port2 (
      .i_in_reset   (w_in_reset),
      .i_rd_addr    (rd_addr2),
      .i_regs       (r_regs),
      .i_pending    (r_pending),
      .i_we         (we),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_wr_be      (wr_be),
      .i_issue_valid(issue_valid),
      .i_issue_addr (issue_addr),
      .o_rd_data    (rd_data2),
      .o_rd_busy    (rd_busy2)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb at default parameters (32-bit, 32 regs, zero reg, bypass).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after that.
module tb_regfile_sb;

   logic        clk;
   logic        reset;
   logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_addr, dbg_addr;
   logic [31:0] rd_data1, rd_data2, wr_data, dbg_data;
   logic        rd_busy1, rd_busy2, we, issue_valid;
   logic [3:0]  wr_be;
   logic [5:0]  pend_cnt;

   int n_vec = 0;
   int n_err = 0;

   regfile_sb dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .rd_data1   (rd_data1),
      .rd_data2   (rd_data2),
      .rd_busy1   (rd_busy1),
      .rd_busy2   (rd_busy2),
      .we         (we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_be      (wr_be),
      .issue_valid(issue_valid),
      .issue_addr (issue_addr),
      .pend_cnt   (pend_cnt),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we          = 1'b0;
      issue_valid = 1'b0;
      wr_be       = 4'h0;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      we      = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
   endtask

   task automatic issue(input logic [4:0] a);
      issue_valid = 1'b1;
      issue_addr  = a;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      wr_addr = 5'd0; wr_data = 32'h0; issue_addr = 5'd0;
      rd_addr1 = 5'd5; rd_addr2 = 5'd7; dbg_addr = 5'd5;
      step(); step();
      n_vec++;
      if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL reset_pend_cnt: got %0d want 0", pend_cnt); end
      n_vec++;
      if (rd_data1 !== 32'h0 || rd_busy1 !== 1'b0) begin
         n_err++; $display("FAIL reset_port1: data=%h busy=%b want 0/0", rd_data1, rd_busy1);
      end
      n_vec++;
      if (dbg_data !== 32'h0) begin n_err++; $display("FAIL reset_dbg: got %h want 0", dbg_data); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_full_write();
      write(5'd5, 32'hDEADBEEF, 4'hF);
      rd_addr1 = 5'd5; rd_addr2 = 5'd5; dbg_addr = 5'd5;
      #1;
      n_vec++;
      if (rd_data1 !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL bypass_full: rd_data1=%h want DEADBEEF", rd_data1);
      end
      n_vec++;
      if (dbg_data !== 32'h0) begin n_err++; $display("FAIL dbg_not_bypassed: got %h want 0", dbg_data); end
      step();
      idle();
      #1;
      n_vec++;
      if (rd_data2 !== 32'hDEADBEEF || dbg_data !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL full_write: rd_data2=%h dbg=%h want DEADBEEF", rd_data2, dbg_data);
      end
   endtask

   task automatic test_byte_write();
      write(5'd5, 32'h11223344, 4'b0101);
      #1;
      n_vec++;
      if (rd_data1 !== 32'hDE22BE44) begin
         n_err++; $display("FAIL bypass_bytes: rd_data1=%h want DE22BE44", rd_data1);
      end
      step();
      idle();
      #1;
      n_vec++;
      if (rd_data1 !== 32'hDE22BE44 || dbg_data !== 32'hDE22BE44) begin
         n_err++; $display("FAIL byte_write: rd_data1=%h dbg=%h want DE22BE44", rd_data1, dbg_data);
      end
   endtask

   task automatic test_zero_reg();
      write(5'd0, 32'hFFFFFFFF, 4'hF);
      rd_addr1 = 5'd0; dbg_addr = 5'd0;
      #1;
      n_vec++;
      if (rd_data1 !== 32'h0) begin n_err++; $display("FAIL zero_bypass: rd_data1=%h want 0", rd_data1); end
      step();
      idle();
      issue(5'd0);
      #1;
      n_vec++;
      if (rd_data1 !== 32'h0 || dbg_data !== 32'h0) begin
         n_err++; $display("FAIL zero_read: rd_data1=%h dbg=%h want 0", rd_data1, dbg_data);
      end
      step();
      idle();
      #1;
      n_vec++;
      if (pend_cnt !== 6'd0 || rd_busy1 !== 1'b0) begin
         n_err++; $display("FAIL zero_issue: pend_cnt=%0d busy=%b want 0/0", pend_cnt, rd_busy1);
      end
   endtask

   task automatic test_pending();
      issue(5'd3);
      step();
      issue(5'd7);
      step();
      idle();
      rd_addr1 = 5'd3; rd_addr2 = 5'd7;
      #1;
      n_vec++;
      if (pend_cnt !== 6'd2 || rd_busy1 !== 1'b1 || rd_busy2 !== 1'b1) begin
         n_err++; $display("FAIL issue_two: pend_cnt=%0d busy1=%b busy2=%b want 2/1/1", pend_cnt, rd_busy1, rd_busy2);
      end
      issue(5'd3);
      step();
      idle();
      #1;
      n_vec++;
      if (pend_cnt !== 6'd2) begin n_err++; $display("FAIL reissue: pend_cnt=%0d want 2", pend_cnt); end
      issue(5'd3);
      write(5'd7, 32'hA5A5A5A5, 4'hF);
      #1;
      n_vec++;
      if (rd_busy2 !== 1'b0 || rd_data2 !== 32'hA5A5A5A5) begin
         n_err++; $display("FAIL busy_bypass: busy2=%b data2=%h want 0/A5A5A5A5", rd_busy2, rd_data2);
      end
      step();
      idle();
      #1;
      n_vec++;
      if (pend_cnt !== 6'd1 || rd_busy1 !== 1'b1 || rd_busy2 !== 1'b0) begin
         n_err++; $display("FAIL issue_and_write: pend_cnt=%0d busy1=%b busy2=%b want 1/1/0", pend_cnt, rd_busy1, rd_busy2);
      end
      write(5'd3, 32'hFFFFFFFF, 4'h0);
      #1;
      n_vec++;
      if (rd_data1 !== 32'h0) begin n_err++; $display("FAIL zero_be_bypass: rd_data1=%h want 0", rd_data1); end
      step();
      idle();
      #1;
      n_vec++;
      if (pend_cnt !== 6'd0 || rd_busy1 !== 1'b0 || rd_data1 !== 32'h0) begin
         n_err++; $display("FAIL zero_be_write: pend_cnt=%0d busy1=%b data1=%h want 0/0/0", pend_cnt, rd_busy1, rd_data1);
      end
   endtask

   task automatic test_issue_write_same();
      issue(5'd9);
      write(5'd9, 32'hCAFEF00D, 4'hF);
      rd_addr1 = 5'd9;
      step();
      idle();
      #1;
      n_vec++;
      if (pend_cnt !== 6'd1 || rd_busy1 !== 1'b1 || rd_data1 !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL issue_wins: pend_cnt=%0d busy1=%b data1=%h want 1/1/CAFEF00D", pend_cnt, rd_busy1, rd_data1);
      end
      issue(5'd9);
      write(5'd9, 32'h0BADC0DE, 4'hF);
      #1;
      n_vec++;
      if (rd_busy1 !== 1'b1) begin n_err++; $display("FAIL issue_wins_busy: busy1=%b want 1", rd_busy1); end
      step();
      idle();
      #1;
      n_vec++;
      if (pend_cnt !== 6'd1 || rd_data1 !== 32'h0BADC0DE) begin
         n_err++; $display("FAIL issue_wins_again: pend_cnt=%0d data1=%h want 1/0BADC0DE", pend_cnt, rd_data1);
      end
   endtask

   task automatic test_reset_midstream();
      issue(5'd1);
      step();
      issue(5'd2);
      step();
      idle();
      #1;
      n_vec++;
      if (pend_cnt !== 6'd3) begin n_err++; $display("FAIL pend_three: pend_cnt=%0d want 3", pend_cnt); end
      write(5'd6, 32'h55AA55AA, 4'hF);
      issue(5'd4);
      rd_addr1 = 5'd9; rd_addr2 = 5'd6; dbg_addr = 5'd5;
      #1;
      reset = 1'b0;
      #1;
      n_vec++;
      if (pend_cnt !== 6'd0 || rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
         n_err++; $display("FAIL async_reset_pend: pend_cnt=%0d busy1=%b busy2=%b want 0/0/0", pend_cnt, rd_busy1, rd_busy2);
      end
      n_vec++;
      if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || dbg_data !== 32'h0) begin
         n_err++; $display("FAIL async_reset_data: d1=%h d2=%h dbg=%h want 0", rd_data1, rd_data2, dbg_data);
      end
      step();
      idle();
      reset = 1'b1;
      rd_addr1 = 5'd5;
      #1;
      n_vec++;
      if (rd_data2 !== 32'h0 || rd_data1 !== 32'h0 || pend_cnt !== 6'd0) begin
         n_err++; $display("FAIL abandoned: r6=%h r5=%h pend_cnt=%0d want 0/0/0", rd_data2, rd_data1, pend_cnt);
      end
      write(5'd6, 32'h12345678, 4'hF);
      issue(5'd6);
      step();
      idle();
      #1;
      n_vec++;
      if (rd_data2 !== 32'h12345678 || pend_cnt !== 6'd1 || rd_busy2 !== 1'b1) begin
         n_err++; $display("FAIL resume: r6=%h pend_cnt=%0d busy2=%b want 12345678/1/1", rd_data2, pend_cnt, rd_busy2);
      end
   endtask

   initial begin
      test_reset();
      test_full_write();
      test_byte_write();
      test_zero_reg();
      test_pending();
      test_issue_write_same();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
